puf_accum: RTL and testbench
============================

# puf_accum

Response accumulator and soft-decision front end for the GF(2) key-recovery eliminator.
- Collects NS repeated M-bit PUF readouts and counts ones per bit.
- Forms each bit's majority value and its reliability, then XORs the majority with the stored helper vector b.
- Hands x_v = b ^ e and the per-bit confidence vector co_v to the downstream eliminator, and holds both stable for the eliminator's whole run.

## Interface
- M, 256, response/helper bit count (rows of the public matrix)
- ACC, 7, confidence width per bit; also the per-bit counter width
- NS, 127, readouts per key recovery; must be odd and 1 <= NS <= 2^ACC-1
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous and active-high
- start  in  1  begin a recovery; sampled only in S_IDLE
- b_v  in  M  helper vector; captured on the accepted start cycle
- busy  out  1  high from accepted start until return to S_IDLE
- sample_valid  in  1  sample_v carries one full PUF readout
- sample_ready  out  1  high only in S_ACC
- sample_v  in  M  readout bits; bit i is response bit i
- x_v  out  M  registered b ^ majority(e)
- co_v  out  ACC*M  registered confidences; bits [i*ACC+ACC-1 : i*ACC] belong to bit i
- req_valid  out  1  request to eliminator
- req_ready  in  1  eliminator acceptance (sticky high once set; informational only)
- req_busy  in  1  eliminator is running and reading x_v/co_v

## Operation
- States: S_IDLE, S_ACC, S_FIN, S_REQ, S_HOLD.
- S_IDLE:
  - start=1 → clear all counters and the sample counter, capture b_v, busy<=1, go to S_ACC.
  - sample_valid is ignored.
- S_ACC:
  - sample_ready=1.
  - Each cycle with sample_valid & sample_ready: cnt[i] += sample_v[i] for all i, and n += 1.
  - When the accepted beat makes n == NS, go to S_FIN; sample_ready drops on the next cycle.
  - Gaps in sample_valid only stall.
- S_FIN, one cycle:
  - maj[i] = (2*cnt[i] > NS).
  - x_v[i] <= b[i] ^ maj[i].
  - co[i] <= |2*cnt[i] - NS|, computed at ACC+1 bits and truncated to ACC (always fits).
  - req_valid <= 1; go to S_REQ.
- S_REQ: when req_busy=1, req_valid <= 0 and go to S_HOLD.
- S_HOLD: when req_busy=0, busy <= 0 and go to S_IDLE.
- x_v/co_v change only in S_FIN, so they stay stable through S_REQ, S_HOLD and the following S_IDLE.
- Counters never exceed NS, so there is no saturation logic.
- start while busy=1 is ignored.

## Timing
- Reset (async) values:
  - all outputs 0: sample_ready, busy, req_valid, x_v, co_v
  - state S_IDLE, counters 0
- Reset asserted mid-operation aborts immediately. Any partially accumulated counts are discarded.
- Edge-by-edge sequence:
  - start is sampled at edge t; busy=1 and sample_ready=1 from t.
  - The NS-th accepted sample is at edge k; state is S_FIN after k.
  - At edge k+1, x_v, co_v and req_valid=1 all update together.
- Minimum start-to-req_valid latency is NS+2 cycles.
- Handshake: req_valid stays high until req_busy=1 is seen, then drops on the next edge.
- If req_busy is already high when S_REQ is entered, req_valid is high for exactly one cycle.
- busy falls one edge after req_busy is first seen low in S_HOLD.

## Structure
- Shared package holds:
  - constants M, ACC, NS
  - the state encoding
  - the co_v slice helper (index → bit range)
  - the elaboration check (NS odd, NS < 2^ACC)
- One natural sub-module, puf_acc_cell, instantiated M times. Each cell owns:
  - its ACC-bit counter with clear/increment
  - its majority and |2c-NS| logic
- The top keeps the FSM, sample counter, b register and output registers.

## Test plan
- b_v=0; 127 readouts of all-ones → x_v all ones, every co=127, req_valid exactly 129 cycles after start (no gaps).
- Bit 0 set in 64 of 127 readouts, bit 1 set in 63, b_v=0x2 → x_v[0]=1, co[0]=1; x_v[1]=1 (0^... → 0 majority, b=1), co[1]=1.
- sample_valid toggled every other cycle → same results; count stops at exactly 127 accepted beats; sample_ready low from S_FIN onward.
- Eliminator model raises req_busy 3 cycles after req_valid and holds it 500 cycles → req_valid drops the cycle after req_busy rises; x_v/co_v bit-stable throughout; busy falls one cycle after req_busy falls.
- start pulsed while in S_ACC and S_HOLD → no effect on counts or outputs.
- rst asserted after 40 samples, then a fresh run → outputs 0 during reset; new run results unaffected by the aborted counts.

Source files
------------

// File: rtl/puf_accum_pkg.sv
// Shared constants, state encoding and helpers for the PUF response accumulator.
// Every puf_accum file imports this package.
package puf_accum_pkg;

  localparam int M    = 256;
  localparam int ACC  = 7;
  localparam int NS   = 127;
  localparam int CO_W = ACC * M;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_FIN,
    S_REQ,
    S_HOLD
  } state_t;

  // Bit range of bit i's confidence inside co_v.
  function automatic int co_lo(input int i);
    return i * ACC;
  endfunction

  function automatic int co_hi(input int i);
    return i * ACC + ACC - 1;
  endfunction

  // An odd NS gives a strict majority. NS < 2^ACC lets a count and |2c-NS| fit in ACC bits.
  localparam bit NS_OK = (NS >= 1) && (NS % 2 == 1) && (NS <= (1 << ACC) - 1);

endpackage

// File: rtl/puf_accum_if.sv
// Bundles the readout stream, the eliminator request and the held soft-decision vectors.
interface puf_accum_if;
  import puf_accum_pkg::*;

  logic                start;
  logic [M-1:0]        b_v;
  logic                busy;
  logic                sample_valid;
  logic                sample_ready;
  logic [M-1:0]        sample_v;
  logic [M-1:0]        x_v;
  logic [CO_W-1:0]     co_v;
  logic                req_valid;
  logic                req_ready;
  logic                req_busy;

  modport master (
    output start, b_v, sample_valid, sample_v, req_ready, req_busy,
    input  busy, sample_ready, x_v, co_v, req_valid
  );

  modport slave (
    input  start, b_v, sample_valid, sample_v, req_ready, req_busy,
    output busy, sample_ready, x_v, co_v, req_valid
  );

endinterface

// File: rtl/puf_acc_cell.sv
// Per-bit ones counter for one response bit.
// Also forms the bit's majority value and its reliability |2c - NS|.
module puf_acc_cell
  import puf_accum_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           inc,
  input  logic           bit_in,
  output logic           maj,
  output logic [ACC-1:0] co
);

  logic [ACC-1:0]        cnt_q, cnt_d;
  logic signed [ACC+1:0] diff;

  // |v| truncated to ACC bits; |2c - NS| never exceeds NS, so nothing is lost.
  function automatic logic [ACC-1:0] abs_trunc(input logic signed [ACC+1:0] v);
    logic signed [ACC+1:0] a;
    a = v[ACC+1] ? -v : v;
    return a[ACC-1:0];
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + ACC'(bit_in);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Signed 2c - NS: a positive result means ones are in the majority.
  always_comb begin
    diff = $signed({1'b0, cnt_q, 1'b0}) - $signed((ACC+2)'(NS));
    maj  = !diff[ACC+1] && (diff != '0);
    co   = abs_trunc(diff);
  end

endmodule

// File: rtl/puf_accum.sv
// Collects NS PUF readouts and emits x_v = b ^ majority plus per-bit confidences.
// Both vectors are held for the downstream eliminator until its next run.
module puf_accum
  import puf_accum_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  puf_accum_if.slave bus
);

  state_t          state_q, state_d;
  logic [ACC-1:0]  n_q, n_d;
  logic [M-1:0]    b_q, b_d;
  logic [M-1:0]    x_q, x_d;
  logic [CO_W-1:0] co_q, co_d;

  logic            clr;
  logic            accept;
  logic            last_beat;
  logic [M-1:0]    maj;
  logic [CO_W-1:0] co_w;

  // req_ready carries no information this block acts on.
  logic            unused_req_ready;
  assign unused_req_ready = bus.req_ready;

  if (!NS_OK) begin : g_ns_check
    $error("puf_accum: NS must be odd and in 1..2^ACC-1");
  end

  assign clr       = (state_q == S_IDLE) && bus.start;
  assign accept    = (state_q == S_ACC) && bus.sample_valid;
  assign last_beat = accept && (n_q == ACC'(NS - 1));

  for (genvar i = 0; i < M; i++) begin : g_cell
    puf_acc_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .inc    (accept),
      .bit_in (bus.sample_v[i]),
      .maj    (maj[i]),
      .co     (co_w[co_lo(i) +: ACC])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start)    state_d = S_ACC;
      S_ACC:   if (last_beat)    state_d = S_FIN;
      S_FIN:                     state_d = S_REQ;
      S_REQ:   if (bus.req_busy) state_d = S_HOLD;
      S_HOLD:  if (!bus.req_busy) state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.sample_ready = (state_q == S_ACC);
    bus.busy         = (state_q != S_IDLE);
    bus.req_valid    = (state_q == S_REQ);
  end

  // Sample counter, helper capture and the result registers loaded only in S_FIN.
  always_comb begin
    n_d  = n_q;
    b_d  = b_q;
    x_d  = x_q;
    co_d = co_q;
    if (clr) begin
      n_d = '0;
      b_d = bus.b_v;
    end else if (accept) begin
      n_d = n_q + 1'b1;
    end
    if (state_q == S_FIN) begin
      x_d  = b_q ^ maj;
      co_d = co_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q  <= '0;
      b_q  <= '0;
      x_q  <= '0;
      co_q <= '0;
    end else begin
      n_q  <= n_d;
      b_q  <= b_d;
      x_q  <= x_d;
      co_q <= co_d;
    end
  end

  assign bus.x_v  = x_q;
  assign bus.co_v = co_q;

endmodule

// File: tb/tb_puf_accum.sv
// Directed table-driven bench for puf_accum: each record describes one recovery run
// with its hand-computed x_v and confidences; corner cases are separate sequences.
module tb_puf_accum;
  import puf_accum_pkg::*;

  typedef struct {
    logic [M-1:0] b;
    int           c0;    // ones count for bit 0
    int           c1;    // ones count for bit 1
    int           cr;    // ones count for every other bit
    bit           gap;   // toggle sample_valid every cycle
    logic [M-1:0] x;
    int           e0;
    int           e1;
    int           er;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[5];

  puf_accum_if bus();

  puf_accum dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  function automatic logic [M-1:0] pat(input vec_t v, input int j);
    logic [M-1:0] s;
    for (int i = 0; i < M; i++) begin
      s[i] = (j < ((i == 0) ? v.c0 : (i == 1) ? v.c1 : v.cr));
    end
    return s;
  endfunction

  function automatic int x_bad(input vec_t v);
    int b = 0;
    for (int i = 0; i < M; i++) if (bus.x_v[i] !== v.x[i]) b++;
    return b;
  endfunction

  function automatic int co_bad(input vec_t v);
    int b = 0;
    logic [ACC-1:0] e;
    for (int i = 0; i < M; i++) begin
      e = ACC'((i == 0) ? v.e0 : (i == 1) ? v.e1 : v.er);
      if (bus.co_v[i*ACC +: ACC] !== e) b++;
    end
    return b;
  endfunction

  // One full recovery plus eliminator handshake.
  task automatic run(input int idx, input bit pulse, input int bdelay, input int hold,
                     input bit early);
    vec_t v;
    int   j = 0;
    int   cyc = 0;
    int   first = -1;
    int   bad = 0;
    bit   acc;
    v = tbl[idx];
    @(negedge clk);
    bus.b_v = v.b;
    bus.start = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_v = pat(v, 0);
    bus.req_busy = early;
    while (first < 0 && cyc < 2000) begin
      acc = bus.sample_valid & bus.sample_ready;
      @(negedge clk);
      cyc++;
      if (acc) begin
        j++;
        if (j == NS) check($sformatf("v%0d_ready_low_fin", idx), bus.sample_ready, 0);
      end
      bus.start = pulse && (cyc == 20);
      bus.sample_valid = v.gap ? ~bus.sample_valid : 1'b1;
      bus.sample_v = pat(v, j);
      if (bus.req_valid === 1'b1) first = cyc;
    end
    bus.sample_valid = 1'b0;
    bus.start = 1'b0;
    if (first < 0) begin
      check($sformatf("v%0d_req_timeout", idx), 1, 0);
      return;
    end
    check($sformatf("v%0d_accepted", idx), j, NS);
    if (!v.gap) check($sformatf("v%0d_latency", idx), first, NS + 2);
    check($sformatf("v%0d_x_bad_bits", idx), x_bad(v), 0);
    check($sformatf("v%0d_co_bad_bits", idx), co_bad(v), 0);
    if (early) begin
      @(negedge clk);
      check($sformatf("v%0d_req_one_cycle", idx), bus.req_valid, 0);
    end else begin
      for (int d = 0; d < bdelay; d++) begin
        if (bus.req_valid !== 1'b1) bad++;
        @(negedge clk);
      end
      check($sformatf("v%0d_req_held", idx), bad, 0);
      bus.req_busy = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_req_drop", idx), bus.req_valid, 0);
    end
    bad = 0;
    for (int h = 0; h < hold; h++) begin
      bad += x_bad(v) + co_bad(v);
      if (bus.busy !== 1'b1 || bus.sample_ready !== 1'b0 || bus.req_valid !== 1'b0) bad++;
      bus.start = pulse;
      @(negedge clk);
      bus.start = 1'b0;
    end
    check($sformatf("v%0d_hold_stable", idx), bad, 0);
    bus.req_busy = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_busy_fall", idx), bus.busy, 0);
    check($sformatf("v%0d_idle_x_bad", idx), x_bad(v) + co_bad(v), 0);
  endtask

  initial begin
    tbl[0] = '{b: '0,        c0: 127, c1: 127, cr: 127, gap: 0, x: '1,
               e0: 127, e1: 127, er: 127};
    tbl[1] = '{b: M'(2),     c0: 64,  c1: 63,  cr: 0,   gap: 0, x: M'(3),
               e0: 1,   e1: 1,   er: 127};
    tbl[2] = '{b: M'(2),     c0: 64,  c1: 63,  cr: 0,   gap: 1, x: M'(3),
               e0: 1,   e1: 1,   er: 127};
    tbl[3] = '{b: '1,        c0: 0,   c1: 127, cr: 100, gap: 0, x: M'(1),
               e0: 127, e1: 127, er: 73};
    tbl[4] = '{b: '0,        c0: 65,  c1: 62,  cr: 31,  gap: 0, x: M'(1),
               e0: 3,   e1: 3,   er: 65};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.b_v = '0;
    bus.sample_valid = 1'b0;
    bus.sample_v = '0;
    bus.req_ready = 1'b0;
    bus.req_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.sample_ready, 0);
    check("rst_req_valid", bus.req_valid, 0);
    check("rst_x_nonzero", bus.x_v !== '0, 0);
    check("rst_co_nonzero", bus.co_v !== '0, 0);
    rst = 1'b0;

    for (int k = 0; k < 5; k++) run(k, 1'b0, 1, 2, 1'b0);

    bus.req_ready = 1'b1;
    run(0, 1'b0, 3, 500, 1'b0);
    run(2, 1'b1, 2, 5, 1'b0);
    run(1, 1'b0, 0, 3, 1'b1);

    // Abort a run after 40 accepted samples, then start a fresh one.
    @(negedge clk);
    bus.b_v = '0;
    bus.start = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_v = '1;
    for (int c = 0; c < 41; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("mid_busy_before_rst", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ready", bus.sample_ready, 0);
    check("mid_rst_req_valid", bus.req_valid, 0);
    check("mid_rst_x_nonzero", bus.x_v !== '0, 0);
    check("mid_rst_co_nonzero", bus.co_v !== '0, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.sample_valid = 1'b0;
    run(1, 1'b0, 1, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
